frac_lutk_arith_cfg: RTL and testbench

Parametrised fracturable K-input LUT logic element with an integrated shadow-and-commit configuration chain, for the next-generation CLB `fle` tile. Configuration bits shift through a private shadow chain on `prog_clk`. They reach the active configuration only through an explicit commit, so the logic function never glitches while a bitstream streams through. A bit counter flags truncated bitstreams through `cfg_valid`.

---
 rtl/frac_lutk_arith_cfg.sv | 134 +++++++++++++
 tb/tb_frac_lutk_arith_cfg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_lutk_arith_cfg.sv
// Fracturable K-input LUT logic element with a shadow-and-commit
// configuration chain. Bits stream into a private shadow register on
// prog_clk and only reach the active configuration through a commit, so
// the logic outputs never glitch while a bitstream passes through.
module frac_lutk_arith_cfg #(
  parameter int unsigned K = 4
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         config_enable,
  input  logic         ccff_head,
  output logic         ccff_tail,
  input  logic [K-1:0] frac_logic_in,
  input  logic         frac_logic_cin,
  output logic [1:0]   frac_logic_out,
  output logic         frac_logic_cout,
  output logic         cfg_valid,
  output logic         cfg_busy
);

  // Legal K range is 3..6; the layout below assumes K >= 2.
  localparam int unsigned TBL_W   = 2 ** K;
  localparam int unsigned HALF_W  = TBL_W / 2;
  localparam int unsigned CFG_W   = TBL_W + 3;
  localparam int unsigned CNT_W   = $clog2(CFG_W + 1);
  localparam int unsigned FRAC_B  = TBL_W;
  localparam int unsigned ARITH_B = TBL_W + 1;
  localparam int unsigned SEL_B   = TBL_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CFG_W-1:0]   shadow, shadow_nxt;
  logic [CFG_W-1:0]   active, active_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               valid_nxt;

  // State, configuration and status registers.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      shadow    <= '0;
      active    <= '0;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      active    <= active_nxt;
      cnt       <= cnt_nxt;
      cfg_valid <= valid_nxt;
      cfg_busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state: shift while enabled, commit one cycle after enable drops.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    active_nxt = active;
    cnt_nxt    = cnt;
    valid_nxt  = cfg_valid;
    case (state)
      IDLE: begin
        if (config_enable) begin
          shadow_nxt = {shadow[CFG_W-2:0], ccff_head};
          cnt_nxt    = CNT_W'(1);
          valid_nxt  = 1'b0;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (config_enable) begin
          shadow_nxt = {shadow[CFG_W-2:0], ccff_head};
          if (cnt != CNT_W'(CFG_W)) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        active_nxt = shadow;
        if (config_enable) begin
          // The head bit presented on this edge is intentionally dropped.
          cnt_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = SHIFT;
        end else begin
          valid_nxt = (cnt == CNT_W'(CFG_W));
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ccff_tail = shadow[CFG_W-1];

  // Logic datapath, purely combinational from the active configuration.
  logic [HALF_W-1:0] tbl_lo, tbl_hi;
  logic [K-2:0]      lut_idx;
  logic              lut_a, lut_b, lutk;
  logic              arith_mode, out0_sel;
  logic              sum, cout_raw;
  logic              unused_frac_mode;

  assign tbl_lo     = active[HALF_W-1:0];
  assign tbl_hi     = active[TBL_W-1:HALF_W];
  assign lut_idx    = frac_logic_in[K-2:0];
  assign arith_mode = active[ARITH_B];
  assign out0_sel   = active[SEL_B];

  // frac_mode only changes how the two half-LUTs are interpreted, not wiring.
  assign unused_frac_mode = active[FRAC_B];

  assign lut_a    = tbl_lo[lut_idx];
  assign lut_b    = tbl_hi[lut_idx];
  assign lutk     = frac_logic_in[K-1] ? lut_b : lut_a;
  assign sum      = lut_a ^ frac_logic_cin;
  assign cout_raw = lut_a ? frac_logic_cin : lut_b;

  assign frac_logic_out[0] = out0_sel ? (arith_mode ? sum : lutk) : lut_a;
  assign frac_logic_out[1] = lut_b;
  assign frac_logic_cout   = arith_mode ? cout_raw : 1'b0;

endmodule

// File: tb/tb_frac_lutk_arith_cfg.sv
// Self-checking bench for frac_lutk_arith_cfg at K=4 (19 config bits).
module tb_frac_lutk_arith_cfg;

  localparam int unsigned CFG_W = 19;
  localparam logic [18:0] XOR4  = 19'h46996;  // sel=1 arith=0 frac=0
  localparam logic [18:0] ARITH = 19'h68866;  // sel=1 arith=1 frac=0
  localparam logic [18:0] FRAC  = 19'h1A53C;  // sel=0 arith=0 frac=1

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       config_enable;
  logic       ccff_head;
  logic       ccff_tail;
  logic [3:0] frac_logic_in;
  logic       frac_logic_cin;
  logic [1:0] frac_logic_out;
  logic       frac_logic_cout;
  logic       cfg_valid;
  logic       cfg_busy;

  frac_lutk_arith_cfg #(.K(4)) dut (
    .prog_clk        (prog_clk),
    .pReset          (pReset),
    .config_enable   (config_enable),
    .ccff_head       (ccff_head),
    .ccff_tail       (ccff_tail),
    .frac_logic_in   (frac_logic_in),
    .frac_logic_cin  (frac_logic_cin),
    .frac_logic_out  (frac_logic_out),
    .frac_logic_cout (frac_logic_cout),
    .cfg_valid       (cfg_valid),
    .cfg_busy        (cfg_busy)
  );

  always #5 prog_clk = ~prog_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference view of the configuration as whole words.
  logic [18:0] m_shadow;
  logic [18:0] m_active;

  typedef struct {
    logic [18:0] cfg;
    logic [3:0]  in;
    logic        cin;
    logic [2:0]  exp;  // {cout, out[1], out[0]}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural element: table lookup by shifting, then mode selection.
  function automatic logic [2:0] model(input logic [18:0] c, input logic [3:0] in, input logic cin);
    int unsigned tbl;
    logic a, b, lk, s, co, o0;
    tbl = 32'(c[15:0]);
    a   = 1'((tbl >> in[2:0]) & 1);
    b   = 1'((tbl >> (32'(in[2:0]) + 8)) & 1);
    lk  = in[3] ? b : a;
    s   = a ^ cin;
    co  = c[17] ? (a ? cin : b) : 1'b0;
    o0  = c[18] ? (c[17] ? s : lk) : a;
    return {co, b, o0};
  endfunction

  function automatic logic [31:0] dut_out();
    return 32'({frac_logic_cout, frac_logic_out});
  endfunction

  task automatic apply_check(input string name, input logic [3:0] in, input logic cin, input logic [2:0] exp);
    frac_logic_in  = in;
    frac_logic_cin = cin;
    #1;
    chk(name, dut_out(), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge prog_clk);
    pReset = 1'b1;
    config_enable = 1'b0;
    #1;
    m_shadow = '0;
    m_active = '0;
    @(negedge prog_clk);
    pReset = 1'b0;
  endtask

  // Drop enable, let the commit happen, check status against shift count.
  task automatic commit(input int nbits);
    @(negedge prog_clk);
    chk("busy_shift", 32'(cfg_busy), 32'd1);
    config_enable = 1'b0;
    @(negedge prog_clk);
    chk("busy_commit", 32'(cfg_busy), 32'd1);
    chk("hold_pre_commit", dut_out(), 32'(model(m_active, frac_logic_in, frac_logic_cin)));
    @(negedge prog_clk);
    m_active = m_shadow;
    chk("valid_after_commit", 32'(cfg_valid), 32'(nbits >= CFG_W));
    chk("idle_after_commit", 32'(cfg_busy), 32'd0);
  endtask

  // Shift the low nbits of cfg MSB-first, outputs must hold meanwhile.
  task automatic load(input logic [18:0] cfg, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge prog_clk);
      chk("hold_out", dut_out(), 32'(model(m_active, frac_logic_in, frac_logic_cin)));
      config_enable = 1'b1;
      ccff_head     = cfg[i];
      m_shadow      = {m_shadow[17:0], cfg[i]};
    end
    commit(nbits);
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 32; i++) begin
      apply_check(name, 4'(i), 1'(i >> 4), model(m_active, 4'(i), 1'(i >> 4)));
    end
  endtask

  initial begin
    logic [18:0] cur_cfg;
    logic [9:0]  tbits;
    logic        bq[$];

    vecs[0] = '{XOR4,  4'b0111, 1'b0, 3'b001};
    vecs[1] = '{XOR4,  4'b0011, 1'b0, 3'b010};
    vecs[2] = '{XOR4,  4'b1000, 1'b1, 3'b011};
    vecs[3] = '{ARITH, 4'b0011, 1'b1, 3'b111};
    vecs[4] = '{ARITH, 4'b0001, 1'b1, 3'b100};
    vecs[5] = '{ARITH, 4'b0000, 1'b1, 3'b001};
    vecs[6] = '{ARITH, 4'b0001, 1'b0, 3'b001};
    vecs[7] = '{FRAC,  4'b1010, 1'b0, 3'b011};
    vecs[8] = '{FRAC,  4'b0101, 1'b1, 3'b011};
    vecs[9] = '{FRAC,  4'b0000, 1'b0, 3'b010};

    pReset = 1'b1;
    config_enable = 1'b0;
    ccff_head = 1'b0;
    frac_logic_in = '0;
    frac_logic_cin = 1'b0;
    m_shadow = '0;
    m_active = '0;

    // Reset values, outputs stay 0 while inputs toggle.
    repeat (2) @(negedge prog_clk);
    chk("rst_tail", 32'(ccff_tail), 32'd0);
    chk("rst_valid", 32'(cfg_valid), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    for (int i = 0; i < 16; i++) apply_check("rst_out", 4'(i), 1'b1, 3'b000);
    pReset = 1'b0;

    // Table-driven known-answer vectors.
    cur_cfg = 'x;
    foreach (vecs[i]) begin
      if (vecs[i].cfg !== cur_cfg) begin
        @(negedge prog_clk);
        load(vecs[i].cfg, CFG_W);
        cur_cfg = vecs[i].cfg;
      end
      apply_check("vec", vecs[i].in, vecs[i].cin, vecs[i].exp);
    end

    // Truncated load from a cleared chain: 10 bits, commit, not valid.
    do_reset();
    tbits = 10'($urandom);
    load({9'b0, tbits}, 10);
    chk("trunc_valid", 32'(cfg_valid), 32'd0);
    sweep("trunc_out");

    // Pass-through: 38 bits, tail is head delayed by 19 shifts.
    do_reset();
    for (int k = 0; k < 38; k++) begin
      @(negedge prog_clk);
      config_enable = 1'b1;
      ccff_head     = 1'($urandom);
      m_shadow      = {m_shadow[17:0], ccff_head};
      bq.push_back(ccff_head);
      @(posedge prog_clk);
      #1;
      chk("tail", 32'(ccff_tail), (bq.size() >= 19) ? 32'(bq[bq.size() - 19]) : 32'd0);
    end
    commit(38);
    sweep("pass_out");

    // Re-enable during COMMIT: commit still lands, head bit dropped, not valid.
    load(XOR4, CFG_W);
    for (int i = 18; i >= 0; i--) begin
      @(negedge prog_clk);
      config_enable = 1'b1;
      ccff_head     = ARITH[i];
      m_shadow      = {m_shadow[17:0], ARITH[i]};
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    @(negedge prog_clk);
    config_enable = 1'b1;
    ccff_head     = 1'b1;
    @(negedge prog_clk);
    m_active = m_shadow;
    chk("recommit_busy", 32'(cfg_busy), 32'd1);
    chk("recommit_valid", 32'(cfg_valid), 32'd0);
    apply_check("recommit_out", 4'b0011, 1'b1, 3'b111);
    config_enable = 1'b0;
    @(negedge prog_clk);
    @(negedge prog_clk);
    chk("zero_cnt_valid", 32'(cfg_valid), 32'd0);
    chk("zero_cnt_idle", 32'(cfg_busy), 32'd0);
    sweep("dropped_bit_out");
    load(ARITH, CFG_W);

    // Reset mid-shift of a valid XOR4 load, then a full reload.
    load(XOR4, CFG_W);
    for (int i = 18; i >= 12; i--) begin
      @(negedge prog_clk);
      config_enable = 1'b1;
      ccff_head     = XOR4[i];
    end
    @(negedge prog_clk);
    pReset = 1'b1;
    #1;
    m_shadow = '0;
    m_active = '0;
    chk("midrst_valid", 32'(cfg_valid), 32'd0);
    chk("midrst_busy", 32'(cfg_busy), 32'd0);
    chk("midrst_tail", 32'(ccff_tail), 32'd0);
    apply_check("midrst_out", 4'b0111, 1'b1, 3'b000);
    config_enable = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b0;
    load(XOR4, CFG_W);
    apply_check("reload_xor_1", 4'b0111, 1'b0, 3'b001);
    apply_check("reload_xor_0", 4'b0011, 1'b0, 3'b010);

    // Random configurations against the reference model.
    for (int r = 0; r < 15; r++) begin
      load(19'($urandom), CFG_W);
      for (int j = 0; j < 8; j++) begin
        logic [3:0] rin;
        logic       rcin;
        rin  = 4'($urandom);
        rcin = 1'($urandom);
        apply_check("rand_out", rin, rcin, model(m_active, rin, rcin));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
